negc_pipe: RTL and testbench
============================

// Module: negc_pipe
// PURPOSE
// - Pipelined, multi-lane successor of the conditional 2's complementer: per lane, Z = f(A, Mode).
// - Modes: pass, negate, absolute value, negative absolute value.
// - Valid/ready streaming interface with STAGES register stages and per-lane overflow flags.
// - Sits between datapath operand registers and downstream adders/multipliers in ELAU-based datapaths.
// PARAMETERS
// - width  8     lane word width in bits, >= 2
// - lanes  4     number of independent lanes sharing one handshake, >= 1
// - stages 2     pipeline register stages = latency in cycles, >= 1
// - speed  lau_pkg::FAST  prefix-logic performance, passed to the combinational NegC per lane
// PORTS
// - CLK       in   1             clock, all state on rising edge
// - RSTN      in   1             asynchronous active-low reset
// - InValid   in   1             input beat valid
// - InReady   out  1             input beat accepted when InValid & InReady
// - A         in   lanes*width   operands; lane i = A[i*width +: width]
// - Mode      in   2             00 pass, 01 negate, 10 abs, 11 -abs; sampled with the beat
// - OutValid  out  1             output beat valid
// - OutReady  in   1             downstream accept
// - Z         out  lanes*width   results, same lane packing as A
// - Ovf       out  lanes         per-lane overflow: result not representable
// - OvfCnt    out  16            saturating count of accepted output beats with any Ovf bit set
// BEHAVIOUR
// - Reset (RSTN low, async): all stage valids 0, OutValid 0, Z 0, Ovf 0, OvfCnt 0. InReady is
//   combinational and reads 1 during reset. A beat in flight is dropped; no beat is emitted after reset.
// - Negation decision per lane: neg = Mode==01 | (Mode==10 & A[msb]) | (Mode==11 & ~A[msb]);
//   Mode==00 gives neg=0. The lane result is computed by NegC(A, neg), combinationally, before stage 1.
// - Overflow: Ovf[i] = neg & (A_i == {1'b1, {width-1{1'b0}}}). Only modes 01 and 10 can raise it.
// - Pipeline: stage k holds {valid_k, Z_k, Ovf_k}, k = 1..stages; stage 1 is loaded from the input.
//   - ready_k = ~valid_k | ready_{k+1}; ready_{stages+1} = OutReady; InReady = ready_1.
//   - Stage k loads from stage k-1 when ready_k; valid_k <= valid_{k-1} (the input stage uses InValid).
//   - The ready chain is combinational: no bubbles, full throughput of 1 beat/cycle at OutReady = 1.
// - Latency: a beat accepted in cycle t is presented with OutValid = 1 in cycle t + stages.
// - Output: OutValid = valid_stages; Z/Ovf = last stage regs.
//   While OutValid & ~OutReady, Z/Ovf/OutValid hold stable.
// - Full pipeline, OutReady low: InReady = 0; no data is overwritten.
// - Full pipeline, OutReady high: accept and emit in the same cycle.
// - Beats leave in acceptance order. Mode is per beat: a mode change between beats affects only later beats.
// - OvfCnt: increments by 1 on each output handshake (OutValid & OutReady) with |Ovf;
//   it holds at 16'hFFFF (no wrap) and is cleared only by reset.
// - Data regs need not be cleared when a stage is empty. Only the valid regs and OvfCnt need reset;
//   Z/Ovf are reset to 0 as stated above.
// CONFIGURATION
// - Macro NEGC_PIPE_SAT_EN:
//   - Defined: an overflowing lane saturates, Z_i = {1'b0, {width-1{1'b1}}} (max positive), and Ovf_i = 1.
//   - Undefined: an overflowing lane wraps, Z_i = A_i (most negative value unchanged), and Ovf_i = 1.
//   - The macro does not change the Ovf and OvfCnt behaviour or the timing.
// TESTING
// - Reset: RSTN=0 mid-stream with 2 beats in flight -> OutValid=0, Z=0, Ovf=0, OvfCnt=0.
//   After release no stale beat appears.
// - Modes: width=8, lane A=8'hF6 (-10) -> Z=F6 (00), 0A (01), 0A (10), F6 (11); A=8'h05 in mode 11 -> FB.
//   Each Z appears exactly stages cycles after acceptance.
// - Overflow: A=8'h80, Mode=10 -> Ovf=1, Z=80 without the macro, 7F with NEGC_PIPE_SAT_EN, OvfCnt=1.
//   Mode=11 on 8'h80 -> Z=80, Ovf=0.
// - Back-pressure: stream 10 beats with OutReady=0 for 5 cycles -> InReady=0 once stages beats are held.
//   Output holds stable; after release all 10 beats arrive in order with none lost or duplicated.
// - Throughput: InValid=OutReady=1 for 100 cycles, random A/Mode, lanes=4 -> one beat per cycle.
//   Every lane matches the behavioural model Neg ? -A : A.
// - OvfCnt saturation: force 65540 overflowing beats (or preload in a test build) -> OvfCnt=16'hFFFF and holds.

Source files
------------

// File: rtl/negc_pipe.sv
// negc_pipe: pipelined, multi-lane conditional two's complementer.
//
// Each lane computes Z = f(A, Mode): 00 pass, 01 negate, 10 abs, 11 -abs.
// The lane result is formed combinationally and then carried through
// `stages` register stages. All lanes share one valid/ready handshake.
// The ready chain is combinational, so the pipeline has no bubbles and
// can accept and emit one beat per cycle.
//
// Ports:
//   CLK       in   1             clock, rising edge
//   RSTN      in   1             asynchronous active-low reset
//   InValid   in   1             input beat valid
//   InReady   out  1             input beat accepted when InValid & InReady
//   A         in   lanes*width   operands, lane i = A[i*width +: width]
//   Mode      in   2             00 pass, 01 negate, 10 abs, 11 -abs
//   OutValid  out  1             output beat valid
//   OutReady  in   1             downstream accept
//   Z         out  lanes*width   results, same lane packing as A
//   Ovf       out  lanes         per-lane overflow (result not representable)
//   OvfCnt    out  16            saturating count of emitted beats with any Ovf
//
// Configuration macro NEGC_PIPE_SAT_EN:
//   defined   -> an overflowing lane saturates to the maximum positive value
//   undefined -> an overflowing lane wraps (most negative value unchanged)

package lau_pkg;
  typedef enum logic [0:0] {
    FAST = 1'b0,
    SLOW = 1'b1
  } speed_e;
endpackage

module negc_pipe #(
  parameter int              width  = 8,
  parameter int              lanes  = 4,
  parameter int              stages = 2,
  parameter lau_pkg::speed_e speed  = lau_pkg::FAST
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic                   InValid,
  output logic                   InReady,
  input  logic [lanes*width-1:0] A,
  input  logic [1:0]             Mode,
  output logic                   OutValid,
  input  logic                   OutReady,
  output logic [lanes*width-1:0] Z,
  output logic [lanes-1:0]       Ovf,
  output logic [15:0]            OvfCnt
);

  localparam logic [width-1:0] MostNeg = {1'b1, {(width-1){1'b0}}};
  localparam logic [width-1:0] MaxPos  = {1'b0, {(width-1){1'b1}}};

  logic [lanes*width-1:0] laneZ;
  logic [lanes-1:0]       laneOvf;

  // Per-lane NegC: decide whether to negate, then form (A ^ neg) + neg.
  for (genvar i = 0; i < lanes; i++) begin : g_lane
    logic [width-1:0] laneA;
    logic [width-1:0] negRes;
    logic             neg;
    logic             ovf;

    assign laneA = A[i*width +: width];

    always_comb begin
      neg = 1'b0;
      case (Mode)
        2'b01:   neg = 1'b1;
        2'b10:   neg = laneA[width-1];
        2'b11:   neg = ~laneA[width-1];
        default: neg = 1'b0;
      endcase
    end

    if (speed == lau_pkg::FAST) begin : g_fast
      // Leave the increment to the synthesis tool's fast adder.
      assign negRes = (laneA ^ {width{neg}}) + {{(width-1){1'b0}}, neg};
    end else begin : g_ripple
      // Explicit ripple of half adders: smallest, slowest increment.
      logic [width-1:0] carry;
      always_comb begin
        carry    = '0;
        negRes   = '0;
        carry[0] = neg;
        for (int j = 0; j < width; j++) begin
          negRes[j] = (laneA[j] ^ neg) ^ carry[j];
          if (j < width - 1) begin
            carry[j+1] = (laneA[j] ^ neg) & carry[j];
          end
        end
      end
    end

    // Only negating the most negative value cannot be represented.
    assign ovf        = neg & (laneA == MostNeg);
    assign laneOvf[i] = ovf;

`ifdef NEGC_PIPE_SAT_EN
    assign laneZ[i*width +: width] = ovf ? MaxPos : negRes;
`else
    assign laneZ[i*width +: width] = negRes;
`endif
  end

  // Pipeline state and the values each stage would load next.
  logic [stages-1:0]      valid_q;
  logic [lanes*width-1:0] z_q   [stages];
  logic [lanes-1:0]       ovf_q [stages];

  logic [stages-1:0]      valid_d;
  logic [lanes*width-1:0] z_d   [stages];
  logic [lanes-1:0]       ovf_d [stages];

  logic [stages:0]        ready;
  logic [15:0]            ovfCnt_q;

  // Backwards ready chain: a stage can load if it is empty or its
  // successor is loading this cycle.
  always_comb begin
    ready         = '0;
    ready[stages] = OutReady;
    for (int k = stages - 1; k >= 0; k--) begin
      ready[k] = ~valid_q[k] | ready[k+1];
    end
  end

  // Stage 0 is fed from the combinational lane results, later stages
  // from their predecessor.
  always_comb begin
    valid_d[0] = InValid;
    z_d[0]     = laneZ;
    ovf_d[0]   = laneOvf;
    for (int k = 1; k < stages; k++) begin
      valid_d[k] = valid_q[k-1];
      z_d[k]     = z_q[k-1];
      ovf_d[k]   = ovf_q[k-1];
    end
  end

  // Stage registers: a stage only changes when it is allowed to load,
  // so a stalled output holds its data.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      valid_q <= '0;
      for (int k = 0; k < stages; k++) begin
        z_q[k]   <= '0;
        ovf_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < stages; k++) begin
        if (ready[k]) begin
          valid_q[k] <= valid_d[k];
          z_q[k]     <= z_d[k];
          ovf_q[k]   <= ovf_d[k];
        end
      end
    end
  end

  // Count emitted beats that carry any overflow; stick at all-ones.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ovfCnt_q <= '0;
    end else if (OutValid && OutReady && (|Ovf) && (ovfCnt_q != 16'hFFFF)) begin
      ovfCnt_q <= ovfCnt_q + 16'd1;
    end
  end

  assign InReady  = ready[0];
  assign OutValid = valid_q[stages-1];
  assign Z        = z_q[stages-1];
  assign Ovf      = ovf_q[stages-1];
  assign OvfCnt   = ovfCnt_q;

endmodule

// File: tb/tb_negc_pipe.sv
// tb_negc_pipe: directed self-checking bench for negc_pipe
// (width 8, lanes 4, stages 2).

module tb_negc_pipe;

  localparam int W = 8;
  localparam int L = 4;
  localparam int S = 2;

  logic           CLK  = 1'b0;
  logic           RSTN = 1'b0;
  logic           InValid = 1'b0;
  logic           InReady;
  logic [L*W-1:0] A = '0;
  logic [1:0]     Mode = 2'b00;
  logic           OutValid;
  logic           OutReady = 1'b0;
  logic [L*W-1:0] Z;
  logic [L-1:0]   Ovf;
  logic [15:0]    OvfCnt;

  int passCount  = 0;
  int checkCount = 0;

  always #5 CLK = ~CLK;

  negc_pipe #(
    .width (W),
    .lanes (L),
    .stages(S)
  ) dut (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .InValid (InValid),
    .InReady (InReady),
    .A       (A),
    .Mode    (Mode),
    .OutValid(OutValid),
    .OutReady(OutReady),
    .Z       (Z),
    .Ovf     (Ovf),
    .OvfCnt  (OvfCnt)
  );

  // Expected beats in acceptance order, plus a model of the overflow counter.
  logic [L*W-1:0] expZq [$];
  logic [L-1:0]   expOq [$];
  logic [15:0]    modelCnt = '0;

  // Observations of the most recent cycle.
  logic           inFire, outFire, obsValid, spurious;
  logic [L*W-1:0] outZ, expZ;
  logic [L-1:0]   outOvf, expOvf;

  // Behavioural lane model: Neg ? -A : A, with overflow when -A exceeds the range.
  function automatic void modelBeat(input logic [L*W-1:0] a, input logic [1:0] m,
                                    output logic [L*W-1:0] z, output logic [L-1:0] o);
    z = '0;
    o = '0;
    for (int i = 0; i < L; i++) begin
      logic [W-1:0] ai;
      logic [W-1:0] ri;
      int           v;
      bit           neg;
      ai  = a[i*W +: W];
      v   = int'($signed(ai));
      neg = (m == 2'b01) || (m == 2'b10 && v < 0) || (m == 2'b11 && v >= 0);
      ri  = neg ? W'(-v) : ai;
      o[i] = neg && (-v > (1 << (W - 1)) - 1);
`ifdef NEGC_PIPE_SAT_EN
      if (o[i]) ri = W'((1 << (W - 1)) - 1);
`endif
      z[i*W +: W] = ri;
    end
  endfunction

  // One cycle: drive inputs just after the falling edge, observe, book-keep
  // the expected queue, then wait for the next falling edge.
  task automatic pump(input logic iv, input logic [L*W-1:0] a, input logic [1:0] m,
                      input logic ordy);
    logic [L*W-1:0] ez;
    logic [L-1:0]   eo;
    InValid  = iv;
    A        = a;
    Mode     = m;
    OutReady = ordy;
    #1;
    inFire   = InValid & InReady;
    outFire  = OutValid & OutReady;
    obsValid = OutValid;
    outZ     = Z;
    outOvf   = Ovf;
    spurious = 1'b0;
    if (inFire) begin
      modelBeat(a, m, ez, eo);
      expZq.push_back(ez);
      expOq.push_back(eo);
    end
    if (outFire) begin
      if (expZq.size() == 0) begin
        spurious = 1'b1;
      end else begin
        expZ   = expZq.pop_front();
        expOvf = expOq.pop_front();
        if ((|expOvf) && modelCnt != 16'hFFFF) modelCnt = modelCnt + 16'd1;
      end
    end
    @(negedge CLK);
  endtask

  // Send one beat into an empty pipe and wait (bounded) for it to emerge.
  task automatic sendOne(input logic [L*W-1:0] a, input logic [1:0] m,
                         output int lat, output logic [L*W-1:0] z, output logic [L-1:0] o);
    lat = 0;
    z   = '0;
    o   = '0;
    pump(1'b1, a, m, 1'b1);
    if (!inFire) return;
    for (int c = 1; c <= 10; c++) begin
      pump(1'b0, '0, 2'b00, 1'b1);
      if (outFire) begin
        lat = c;
        z   = outZ;
        o   = outOvf;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int sawValid;
    @(negedge CLK);
    checkCount++;
    if (OutValid !== 1'b0) $display("[TB] FAIL reset_outvalid: got %b expected 0", OutValid); else passCount++;
    checkCount++;
    if (Z !== '0) $display("[TB] FAIL reset_z: got %h expected 0", Z); else passCount++;
    checkCount++;
    if (Ovf !== '0) $display("[TB] FAIL reset_ovf: got %b expected 0", Ovf); else passCount++;
    checkCount++;
    if (OvfCnt !== 16'h0000) $display("[TB] FAIL reset_ovfcnt: got %h expected 0000", OvfCnt); else passCount++;
    checkCount++;
    if (InReady !== 1'b1) $display("[TB] FAIL reset_inready: got %b expected 1", InReady); else passCount++;

    RSTN = 1'b1;
    pump(1'b1, {4{8'h80}}, 2'b10, 1'b1);
    pump(1'b1, {4{8'h05}}, 2'b00, 1'b1);
    pump(1'b1, {4{8'h06}}, 2'b00, 1'b1);
    pump(1'b1, {4{8'h07}}, 2'b00, 1'b1);
    checkCount++;
    if (OvfCnt !== 16'h0001) $display("[TB] FAIL prereset_ovfcnt: got %h expected 0001", OvfCnt); else passCount++;

    // Two beats are still in flight; pull reset in the middle of the cycle.
    InValid = 1'b0;
    #2;
    RSTN = 1'b0;
    #1;
    checkCount++;
    if (OutValid !== 1'b0) $display("[TB] FAIL midreset_outvalid: got %b expected 0", OutValid); else passCount++;
    checkCount++;
    if (Z !== '0) $display("[TB] FAIL midreset_z: got %h expected 0", Z); else passCount++;
    checkCount++;
    if (Ovf !== '0) $display("[TB] FAIL midreset_ovf: got %b expected 0", Ovf); else passCount++;
    checkCount++;
    if (OvfCnt !== 16'h0000) $display("[TB] FAIL midreset_ovfcnt: got %h expected 0000", OvfCnt); else passCount++;

    @(negedge CLK);
    RSTN = 1'b1;
    expZq.delete();
    expOq.delete();
    modelCnt = '0;
    sawValid = 0;
    for (int c = 0; c < 6; c++) begin
      pump(1'b0, '0, 2'b00, 1'b1);
      if (obsValid) sawValid++;
    end
    checkCount++;
    if (sawValid != 0) $display("[TB] FAIL reset_stale_beat: got %0d beats expected 0", sawValid); else passCount++;
  endtask

  task automatic test_modes();
    logic [L*W-1:0] expz [4];
    logic [L*W-1:0] z;
    logic [L-1:0]   o;
    int             lat;
    // Lanes 3..0 = 05, F6 (-10), 7F, 00.
    expz[0] = 32'h05F67F00;
    expz[1] = 32'hFB0A8100;
    expz[2] = 32'h050A7F00;
    expz[3] = 32'hFBF68100;
    for (int m = 0; m < 4; m++) begin
      sendOne(32'h05F67F00, 2'(m), lat, z, o);
      checkCount++;
      if (z !== expz[m]) $display("[TB] FAIL mode%0d_z: got %h expected %h", m, z, expz[m]); else passCount++;
      checkCount++;
      if (o !== 4'b0000) $display("[TB] FAIL mode%0d_ovf: got %b expected 0000", m, o); else passCount++;
      checkCount++;
      if (lat != S) $display("[TB] FAIL mode%0d_latency: got %0d expected %0d", m, lat, S); else passCount++;
    end
  endtask

  task automatic test_overflow();
    logic [L*W-1:0] z;
    logic [L-1:0]   o;
    int             lat;
    logic [L*W-1:0] expAbs, expNeg;
`ifdef NEGC_PIPE_SAT_EN
    expAbs = 32'h7F7F017F;
    expNeg = 32'h7F7F7F7F;
`else
    expAbs = 32'h80800180;
    expNeg = 32'h80808080;
`endif
    sendOne(32'h80800180, 2'b10, lat, z, o);
    checkCount++;
    if (z !== expAbs) $display("[TB] FAIL ovf_abs_z: got %h expected %h", z, expAbs); else passCount++;
    checkCount++;
    if (o !== 4'b1101) $display("[TB] FAIL ovf_abs_flag: got %b expected 1101", o); else passCount++;
    checkCount++;
    if (lat != S) $display("[TB] FAIL ovf_abs_latency: got %0d expected %0d", lat, S); else passCount++;
    checkCount++;
    if (OvfCnt !== 16'h0001) $display("[TB] FAIL ovf_abs_cnt: got %h expected 0001", OvfCnt); else passCount++;

    sendOne(32'h80808080, 2'b11, lat, z, o);
    checkCount++;
    if (z !== 32'h80808080) $display("[TB] FAIL ovf_nabs_z: got %h expected 80808080", z); else passCount++;
    checkCount++;
    if (o !== 4'b0000) $display("[TB] FAIL ovf_nabs_flag: got %b expected 0000", o); else passCount++;
    checkCount++;
    if (OvfCnt !== 16'h0001) $display("[TB] FAIL ovf_nabs_cnt: got %h expected 0001", OvfCnt); else passCount++;

    sendOne(32'h80808080, 2'b01, lat, z, o);
    checkCount++;
    if (z !== expNeg) $display("[TB] FAIL ovf_neg_z: got %h expected %h", z, expNeg); else passCount++;
    checkCount++;
    if (o !== 4'b1111) $display("[TB] FAIL ovf_neg_flag: got %b expected 1111", o); else passCount++;
    checkCount++;
    if (OvfCnt !== 16'h0002) $display("[TB] FAIL ovf_neg_cnt: got %h expected 0002", OvfCnt); else passCount++;
  endtask

  task automatic test_back_pressure();
    int             sent = 0;
    int             got = 0;
    int             stallBad = 0;
    int             stableBad = 0;
    int             orderBad = 0;
    logic           ordy;
    logic [L*W-1:0] heldZ = '0;
    int             prevSent;
    for (int c = 0; c < 40 && got < 10; c++) begin
      ordy     = (c >= 5);
      prevSent = sent;
      pump(sent < 10, {4{8'(sent + 1)}}, 2'(sent % 4), ordy);
      if (inFire) sent++;
      if (!ordy && prevSent >= S && inFire) stallBad++;
      if (c == S) heldZ = outZ;
      if (c >= S && c < 5 && (!obsValid || outZ !== heldZ)) stableBad++;
      if (outFire) begin
        got++;
        if (spurious || outZ !== expZ || outOvf !== expOvf) orderBad++;
      end
    end
    checkCount++;
    if (stallBad != 0) $display("[TB] FAIL bp_inready_full: got %0d accepts expected 0", stallBad); else passCount++;
    checkCount++;
    if (stableBad != 0) $display("[TB] FAIL bp_output_hold: got %0d unstable cycles expected 0", stableBad); else passCount++;
    checkCount++;
    if (got != 10) $display("[TB] FAIL bp_beat_count: got %0d expected 10", got); else passCount++;
    checkCount++;
    if (orderBad != 0) $display("[TB] FAIL bp_order: got %0d wrong beats expected 0", orderBad); else passCount++;
  endtask

  task automatic test_throughput();
    int acc = 0;
    int fired = 0;
    int bad = 0;
    int gaps = 0;
    for (int c = 0; c < 100; c++) begin
      pump(1'b1, L*W'($urandom), 2'($urandom_range(0, 3)), 1'b1);
      if (inFire) acc++;
      if (c >= S && !outFire) gaps++;
      if (outFire) begin
        fired++;
        if (spurious || outZ !== expZ || outOvf !== expOvf) bad++;
      end
    end
    for (int c = 0; c < 20 && expZq.size() > 0; c++) begin
      pump(1'b0, '0, 2'b00, 1'b1);
      if (outFire) begin
        fired++;
        if (spurious || outZ !== expZ || outOvf !== expOvf) bad++;
      end
    end
    checkCount++;
    if (acc != 100) $display("[TB] FAIL tp_accepted: got %0d expected 100", acc); else passCount++;
    checkCount++;
    if (gaps != 0) $display("[TB] FAIL tp_bubbles: got %0d expected 0", gaps); else passCount++;
    checkCount++;
    if (fired != 100) $display("[TB] FAIL tp_emitted: got %0d expected 100", fired); else passCount++;
    checkCount++;
    if (bad != 0) $display("[TB] FAIL tp_data: got %0d wrong beats expected 0", bad); else passCount++;
  endtask

  task automatic drainAll();
    for (int c = 0; c < 20 && expZq.size() > 0; c++) begin
      pump(1'b0, '0, 2'b00, 1'b1);
    end
    pump(1'b0, '0, 2'b00, 1'b1);
  endtask

  task automatic test_ovfcnt_sat();
    int need;
    int sent = 0;
    need = 65534 - int'(modelCnt);
    for (int g = 0; g < need + 100 && sent < need; g++) begin
      pump(1'b1, {4{8'h80}}, 2'b01, 1'b1);
      if (inFire) sent++;
    end
    drainAll();
    checkCount++;
    if (OvfCnt !== 16'hFFFE) $display("[TB] FAIL sat_before_top: got %h expected FFFE", OvfCnt); else passCount++;

    sent = 0;
    for (int g = 0; g < 100 && sent < 6; g++) begin
      pump(1'b1, {4{8'h80}}, 2'b10, 1'b1);
      if (inFire) sent++;
    end
    drainAll();
    checkCount++;
    if (OvfCnt !== 16'hFFFF) $display("[TB] FAIL sat_top: got %h expected FFFF", OvfCnt); else passCount++;
    checkCount++;
    if (expZq.size() != 0) $display("[TB] FAIL sat_drain: got %0d pending expected 0", expZq.size()); else passCount++;

    for (int c = 0; c < 4; c++) pump(1'b0, '0, 2'b00, 1'b1);
    checkCount++;
    if (OvfCnt !== 16'hFFFF) $display("[TB] FAIL sat_hold: got %h expected FFFF", OvfCnt); else passCount++;
  endtask

  initial begin
    test_reset();
    test_modes();
    test_overflow();
    test_back_pressure();
    test_throughput();
    test_ovfcnt_sat();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
